// File: rtl/flex_pkg.sv
// flex_pkg: shared types and constants for the flexible counter bank.
`default_nettype none

package flex_pkg;

  localparam int CNT_MODE_W = 2;

  typedef enum logic [CNT_MODE_W-1:0] {
    MODE_WRAP = 2'b00,
    MODE_STOP = 2'b01
  } cnt_mode_t;

  // Only the exact STOP code stops; 2'b1x falls back to wrapping.
  function automatic logic mode_stops(input logic [CNT_MODE_W-1:0] m);
    return m == MODE_STOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flex_counter_bank_if.sv
// flex_counter_bank_if: control/status bundle for the counter bank.
`default_nettype none

interface flex_counter_bank_if #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2
);
  import flex_pkg::*;

  logic [NUM_CH-1:0]              clear;
  logic [NUM_CH-1:0]              load;
  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CH-1:0]              count_enable;
  logic [NUM_CH-1:0]              count_down;
  logic [NUM_CH*CNT_MODE_W-1:0]   mode;
  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]              rollover_flag;
  logic [NUM_CH-1:0]              rollover_pulse;
  logic                           any_rollover;

  modport master (
    output clear, load, load_val, count_enable, count_down, mode, rollover_val,
    input  count_out, rollover_flag, rollover_pulse, any_rollover
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_down, mode, rollover_val,
    output count_out, rollover_flag, rollover_pulse, any_rollover
  );

endinterface

`default_nettype wire

// File: rtl/flex_counter_ch.sv
// flex_counter_ch: one up/down counter channel with programmable terminal value.
`default_nettype none

module flex_counter_ch
  import flex_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    step_en,
  input  logic                    count_down,
  input  logic [CNT_MODE_W-1:0]   mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count,
  output logic                    flag,
  output logic                    pulse,
  output logic                    wrap_strobe
);

  localparam logic [NUM_CNT_BITS-1:0] C_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] w_term;
  logic [NUM_CNT_BITS-1:0] w_stepped;
  logic                    w_rv_zero;
  logic                    w_at_term;
  logic                    w_stop;
  logic                    w_step;

  assign w_term    = count_down ? C_ONE : rollover_val;
  assign w_rv_zero = (rollover_val == '0);
  assign w_at_term = (count == w_term);
  assign w_stop    = mode_stops(mode);
  assign w_step    = step_en & ~clear & ~load & ~w_rv_zero;

  assign wrap_strobe = w_step & w_at_term & ~w_stop;

  always_comb begin
    w_stepped = count;
    if (count_down) begin
      w_stepped = (count <= C_ONE) ? rollover_val : count - C_ONE;
    end else begin
      w_stepped = (count >= rollover_val) ? C_ONE : count + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      flag  <= 1'b0;
      pulse <= 1'b0;
    end else if (clear) begin
      count <= '0;
      flag  <= 1'b0;
      pulse <= 1'b0;
    end else if (load) begin
      count <= load_val;
      flag  <= ~w_rv_zero & (load_val == w_term);
      pulse <= 1'b0;
    end else if (step_en & w_rv_zero) begin
      // A zero terminal value disables the channel: count freezes, flag drops.
      flag  <= 1'b0;
      pulse <= 1'b0;
    end else if (w_step & ~(w_stop & w_at_term)) begin
      count <= w_stepped;
      flag  <= (w_stepped == w_term);
      pulse <= (w_stepped == w_term) & ~flag;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flex_counter_bank.sv
// flex_counter_bank: NUM_CH flexible counters with optional same-cycle cascading.
`default_nettype none

module flex_counter_bank
  import flex_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2,
  parameter int CASCADE      = 0
) (
  input logic               clk,
  input logic               rst,
  flex_counter_bank_if.slave bus
);

  logic [NUM_CH-1:0] w_step_en;
  logic [NUM_CH-1:0] w_wrap_strobe;
  logic [NUM_CH-1:0] w_pulse;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      if ((CASCADE != 0) && (i > 0)) begin : g_cascade
        // Ripples within one cycle: ch i steps on the same edge ch i-1 wraps.
        assign w_step_en[i] = bus.count_enable[i] & w_wrap_strobe[i-1];
      end else begin : g_direct
        assign w_step_en[i] = bus.count_enable[i];
      end

      flex_counter_ch #(
        .NUM_CNT_BITS(NUM_CNT_BITS)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .clear       (bus.clear[i]),
        .load        (bus.load[i]),
        .load_val    (bus.load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .step_en     (w_step_en[i]),
        .count_down  (bus.count_down[i]),
        .mode        (bus.mode[i*CNT_MODE_W +: CNT_MODE_W]),
        .rollover_val(bus.rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .count       (bus.count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
        .flag        (bus.rollover_flag[i]),
        .pulse       (w_pulse[i]),
        .wrap_strobe (w_wrap_strobe[i])
      );
    end
  endgenerate

  assign bus.rollover_pulse = w_pulse;
  assign bus.any_rollover   = |w_pulse;

  // The last channel's strobe (and all strobes without cascading) have no consumer.
  logic unused_strobes;
  assign unused_strobes = ^w_wrap_strobe;

endmodule

`default_nettype wire

// File: tb/tb_flex_counter_bank.sv
// tb_flex_counter_bank: directed checks of a plain bank and a cascaded bank.
`default_nettype none

module tb_flex_counter_bank;
  import flex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flex_counter_bank_if #(.NUM_CNT_BITS(4), .NUM_CH(2)) bus ();
  flex_counter_bank_if #(.NUM_CNT_BITS(4), .NUM_CH(2)) cbus ();

  flex_counter_bank #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  flex_counter_bank #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)) dut_casc (
    .clk(clk), .rst(rst), .bus(cbus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ch0(input string tag, input int cnt, input bit flg, input bit pls);
    check({tag, " cnt0"},  32'(bus.count_out[3:0]), 32'(cnt));
    check({tag, " flag0"}, 32'(bus.rollover_flag[0]), 32'(flg));
    check({tag, " pls0"},  32'(bus.rollover_pulse[0]), 32'(pls));
  endtask

  task automatic chk_ch1(input string tag, input int cnt, input bit flg, input bit pls);
    check({tag, " cnt1"},  32'(bus.count_out[7:4]), 32'(cnt));
    check({tag, " flag1"}, 32'(bus.rollover_flag[1]), 32'(flg));
    check({tag, " pls1"},  32'(bus.rollover_pulse[1]), 32'(pls));
  endtask

  initial begin
    int up_exp[7]    = '{1, 2, 3, 4, 5, 1, 2};
    int dn_exp[5]    = '{2, 1, 1, 1, 1};
    bit dn_flag[5]   = '{0, 1, 1, 1, 1};
    bit dn_pls[5]    = '{0, 1, 0, 0, 0};
    logic [7:0] casc_cnt[13] = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21,
                                 8'h22, 8'h23, 8'h31, 8'h32, 8'h33, 8'h11};
    logic [1:0] casc_pls[13] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00,
                                 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};

    bus.clear = '0; bus.load = '0; bus.load_val = '0; bus.count_enable = '0;
    bus.count_down = '0; bus.mode = '0; bus.rollover_val = '0;
    cbus.clear = '0; cbus.load = '0; cbus.load_val = '0; cbus.count_enable = '0;
    cbus.count_down = '0; cbus.mode = '0; cbus.rollover_val = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset count",  32'(bus.count_out), 32'h0);
    check("reset flag",   32'(bus.rollover_flag), 32'h0);
    check("reset pulse",  32'(bus.rollover_pulse), 32'h0);
    check("reset any",    32'(bus.any_rollover), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Up count, wrap at 5.
    bus.rollover_val[3:0] = 4'd5;
    bus.count_enable[0]   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_ch0($sformatf("up%0d", i), up_exp[i], up_exp[i] == 5, up_exp[i] == 5);
      check($sformatf("up%0d any", i), 32'(bus.any_rollover), 32'(up_exp[i] == 5));
    end
    bus.count_enable[0] = 1'b0;

    // Asynchronous reset while ch0 sits at 3.
    bus.clear[0] = 1'b1; tick(); bus.clear[0] = 1'b0;
    bus.count_enable[0] = 1'b1;
    repeat (3) tick();
    check("pre-rst cnt0", 32'(bus.count_out[3:0]), 32'd3);
    bus.count_enable[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst cnt", 32'(bus.count_out), 32'h0);
    check("async rst flag", 32'(bus.rollover_flag), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_ch0("post-rst", 0, 0, 0);
    check("post-rst any", 32'(bus.any_rollover), 32'h0);

    // Down count in STOP mode from a loaded 3.
    bus.mode[1:0]        = MODE_STOP;
    bus.count_down[0]    = 1'b1;
    bus.load[0]          = 1'b1;
    bus.load_val[3:0]    = 4'd3;
    tick();
    bus.load[0] = 1'b0;
    chk_ch0("dn load", 3, 0, 0);
    bus.count_enable[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_ch0($sformatf("dn%0d", i), dn_exp[i], dn_flag[i], dn_pls[i]);
    end
    bus.count_enable[0] = 1'b0;
    bus.clear[0] = 1'b1; tick(); bus.clear[0] = 1'b0;
    chk_ch0("dn clear", 0, 0, 0);

    // Priority on ch1: clear beats load and step; load beats step.
    bus.rollover_val[7:4] = 4'd5;
    bus.clear[1] = 1'b1; bus.load[1] = 1'b1; bus.count_enable[1] = 1'b1;
    bus.load_val[7:4] = 4'd7;
    tick();
    chk_ch1("clr>load", 0, 0, 0);
    bus.clear[1] = 1'b0;
    bus.load_val[7:4] = 4'd5;
    tick();
    chk_ch1("load>step", 5, 1, 0);
    bus.load[1] = 1'b0;
    tick();
    chk_ch1("wrap after load", 1, 0, 0);
    bus.count_enable[1] = 1'b0;

    // Zero terminal value freezes the channel.
    bus.rollover_val[7:4] = 4'd0;
    bus.load[1] = 1'b1; bus.load_val[7:4] = 4'd6;
    tick();
    bus.load[1] = 1'b0;
    chk_ch1("rv0 load", 6, 0, 0);
    bus.count_enable[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ch1($sformatf("rv0 hold%0d", i), 6, 0, 0);
    end

    // Terminal value lowered below the current count.
    bus.rollover_val[7:4] = 4'd9;
    tick();
    chk_ch1("rv9 step", 7, 0, 0);
    bus.rollover_val[7:4] = 4'd4;
    tick();
    chk_ch1("rv4 wrap", 1, 0, 0);
    tick(); chk_ch1("rv4 c2", 2, 0, 0);
    tick(); chk_ch1("rv4 c3", 3, 0, 0);
    tick(); chk_ch1("rv4 c4", 4, 1, 1);
    bus.count_enable[1] = 1'b0;

    // Cascaded pair, both terminal at 3.
    cbus.rollover_val = 8'h33;
    cbus.count_enable = 2'b11;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("casc%0d cnt", i), 32'(cbus.count_out), 32'(casc_cnt[i]));
      check($sformatf("casc%0d pls", i), 32'(cbus.rollover_pulse), 32'(casc_pls[i]));
    end
    cbus.count_enable = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
